// File: rtl/alu_result_framer.sv
// ALU result framer: queues {carry, result} requests and serialises each one as a
// 4-byte frame (header, result, flags, checksum) over a start/done byte handshake.
module alu_result_framer #(
    parameter int unsigned       NB_DATA    = 8,
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter logic [NB_DATA-1:0] HEADER    = NB_DATA'(8'hA5)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_result,
    input  logic               i_carry,
    input  logic               i_tx_done,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_byte,
    output logic               o_busy,
    output logic               o_full,
    output logic               o_overflow
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = NB_DATA + 1;
    localparam int unsigned NB_FRAME = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT
    } state_e;

    state_e              state_q, state_d;
    logic [ENT_W-1:0]    mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ENT_W-1:0]    entry_q, entry_d;
    logic [NB_DATA-1:0]  frame_q [NB_FRAME];
    logic [NB_DATA-1:0]  frame_d [NB_FRAME];
    logic [1:0]          idx_q, idx_d;
    logic                pend_q, pend_d;
    logic                start_q, start_d;
    logic [NB_DATA-1:0]  byte_q, byte_d;
    logic                busy_q, busy_d;
    logic                full_q, full_d;
    logic                ovf_q, ovf_d;

    logic                pop;
    logic                push;
    logic                drop;
    logic                fifo_full;
    logic [NB_DATA-1:0]  flags;

    // Request FIFO bookkeeping; a push into a full FIFO survives only if a pop frees a slot.
    always_comb begin
        fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
        pop       = (state_q == ST_IDLE) && (count_q != '0);
        push      = i_valid && (!fifo_full || pop);
        drop      = i_valid && !push;

        wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d   = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        // A drop during LOAD re-arms the flag for the following frame.
        pend_d    = drop || (pend_q && (state_q != ST_LOAD));
        ovf_d     = ovf_q || drop;
        full_d    = (count_d == CNT_W'(FIFO_DEPTH));
    end

    assign flags = NB_DATA'({pend_q, (entry_q[NB_DATA-1:0] == '0), entry_q[NB_DATA]});

    // Frame sequencer: next state, frame latch and transmitter handshake.
    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        frame_d = frame_q;
        idx_d   = idx_q;
        start_d = 1'b0;
        byte_d  = byte_q;

        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    entry_d = mem_q[rd_ptr_q];
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                frame_d[0] = HEADER;
                frame_d[1] = entry_q[NB_DATA-1:0];
                frame_d[2] = flags;
                frame_d[3] = HEADER ^ entry_q[NB_DATA-1:0] ^ flags;
                idx_d      = 2'd0;
                start_d    = 1'b1;
                byte_d     = HEADER;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_tx_done) begin
                    if (idx_q == 2'd3) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        start_d = 1'b1;
                        byte_d  = frame_q[idx_q + 2'd1];
                        state_d = ST_SEND;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // FIFO storage needs no reset: count gates every read.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {i_carry, i_result};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            entry_q  <= '0;
            frame_q  <= '{default: '0};
            idx_q    <= '0;
            pend_q   <= 1'b0;
            start_q  <= 1'b0;
            byte_q   <= '0;
            busy_q   <= 1'b0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            entry_q  <= entry_d;
            frame_q  <= frame_d;
            idx_q    <= idx_d;
            pend_q   <= pend_d;
            start_q  <= start_d;
            byte_q   <= byte_d;
            busy_q   <= busy_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
        end
    end

    assign o_tx_start = start_q;
    assign o_tx_byte  = byte_q;
    assign o_busy     = busy_q;
    assign o_full     = full_q;
    assign o_overflow = ovf_q;

endmodule

// File: doc/alu_result_framer.md
Name: alu_result_framer

Overview:
- Downstream stage between the ALU result and the UART transmitter.
- Captures each completed operation (result byte plus carry) into a small request FIFO.
- Serialises each request as a 4-byte response frame: header, result, flags, checksum.
- Drives the transmitter's start/done handshake one byte at a time, so back-to-back operations are never lost while the line is busy.

Parameters:
NB_DATA, 8, data/result width in bits; every frame byte is NB_DATA wide
FIFO_DEPTH, 4, request FIFO entries; power of 2, minimum 2
HEADER, 8'hA5, constant first byte of every frame

Ports:
i_clk  input  1  system clock; all logic on rising edge
i_reset  input  1  synchronous, active-low reset; i_reset==0 at a rising edge resets the block
i_valid  input  1  one-cycle pulse: i_result/i_carry hold a new operation to report
i_result  input  NB_DATA  ALU result, sampled when i_valid=1
i_carry  input  1  ALU carry, sampled when i_valid=1
i_tx_done  input  1  one-cycle pulse from transmitter: current byte fully sent
o_tx_start  output  1  one-cycle pulse: transmitter loads o_tx_byte
o_tx_byte  output  NB_DATA  byte being transmitted; stable from o_tx_start until the matching i_tx_done
o_busy  output  1  high while a frame is in progress (any state except IDLE)
o_full  output  1  FIFO count == FIFO_DEPTH
o_overflow  output  1  sticky; set when a request is dropped, cleared only by reset

Behaviour:
- Reset: all outputs 0; FIFO empty (pointers and count 0); FSM in IDLE; byte index 0; pending-drop flag 0.
  - Reset is synchronous; it aborts any frame mid-transmission.
  - No further o_tx_start is issued after reset until new requests arrive.
- FIFO:
  - Entry = {carry, result}, NB_DATA+1 bits.
  - Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
  - Push on i_valid.
  - Pop only in the IDLE→LOAD transition.
  - Push while full with a pop in the same cycle: accepted, count unchanged.
  - Push while full with no pop: entry dropped, o_overflow←1, pending-drop←1.
- Frame bytes, registered at LOAD:
  - B0=HEADER
  - B1=result
  - B2={zeros, drop, zero, carry}, where bit0=carry, bit1=(result==0), bit2=pending-drop
  - B3=B0^B1^B2
  - pending-drop clears when it is captured into B2. A drop in the same cycle as LOAD re-sets it for the next frame.
- FSM:
  - IDLE: count!=0 → LOAD (pop); otherwise stay.
  - LOAD: latch B0..B3, index←0 → SEND.
  - SEND: o_tx_start=1 for exactly this cycle; o_tx_byte=B[index] → WAIT.
  - WAIT: hold o_tx_byte. On i_tx_done: if index==3 → IDLE, else index++ → SEND.
- Outputs are registered. o_tx_start is high for exactly one cycle per byte.
- Latency: i_valid at edge N with the FSM idle and FIFO empty → first o_tx_start visible after edge N+2 (push N, pop/LOAD N+1, SEND N+2).
- Between bytes: i_tx_done at edge M → next o_tx_start after edge M+1.
- After the 4th i_tx_done, the FSM returns to IDLE. A queued frame starts LOAD the next cycle; minimum gap between frames is 1 idle cycle.
- i_tx_done outside WAIT (including the SEND cycle) is ignored.
- o_tx_byte retains its last value in IDLE. It is 0 only after reset.
- o_busy=1 in LOAD, SEND and WAIT.

Test Plan:
- Single op: reset, i_valid with result=8'h3C, carry=1 → o_tx_start 2 cycles later; bytes A5, 3C, 01, 98; each start only after the prior i_tx_done; o_busy falls after the 4th done.
- Zero flag: result=0, carry=0 → bytes A5, 00, 02, A7.
- Overflow: 6 i_valid pulses on consecutive cycles (results 1..6) while the transmitter withholds i_tx_done → first frame (result 1) starts. The next four (2..5) queue, filling the FIFO (o_full=1), and result 6 is dropped. o_overflow=1 sticky. The frame for 2 has B2 bit2=1; frames 3..5 have bit2=0.
- Full with simultaneous push/pop: FIFO full, FSM returns to IDLE; i_valid in the same cycle as the pop → no drop; o_overflow stays 0; count stays FIFO_DEPTH.
- Spurious done: i_tx_done pulsed in IDLE and in the SEND cycle → ignored; frame byte sequence is unchanged and still needs 4 WAIT-state dones.
- Reset mid-frame: i_reset=0 for one cycle during WAIT of B2 → next cycle all outputs 0, FSM IDLE, FIFO empty. No o_tx_start until a new i_valid, whose frame starts at B0=A5.
